// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the 9-bit core: sequencer state encoding, opcode
// constants and the instruction-class helpers used by sequencer and decoder.
package prog_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b1010;
  localparam logic [3:0] OP_BTR   = 4'b1011;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam int         CREATE_BIT = 8;

  // Opcode classes only exist when the create bit is clear.
  function automatic logic is_memop(input logic create, input logic [3:0] op);
    return !create && (op == OP_LOAD || op == OP_STORE);
  endfunction

  function automatic logic is_haltop(input logic create, input logic [3:0] op);
    return !create && (op == OP_HALT);
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Sequencer connection bundle: host Start/Done, ROM, decoder flags, ALU flags,
// branch-target LUT and data-memory handshake.
interface prog_sequencer_if #(
  parameter int PC_W = 10
);
  logic            Start;
  logic [PC_W-1:0] StartAddr;
  logic [8:0]      Instruction;
  logic            BeqEn;
  logic            BtrEn;
  logic            ZeroFlag;
  logic            TrueFlag;
  logic [PC_W-1:0] Target;
  logic            MemAck;
  logic [PC_W-1:0] PC;
  logic            MemReq;
  logic            Commit;
  logic            Busy;
  logic            Done;
  logic            Fault;
  logic [15:0]     CycleCnt;

  modport master (
    input  Start, StartAddr, Instruction, BeqEn, BtrEn, ZeroFlag, TrueFlag,
           Target, MemAck,
    output PC, MemReq, Commit, Busy, Done, Fault, CycleCnt
  );

  modport slave (
    output Start, StartAddr, Instruction, BeqEn, BtrEn, ZeroFlag, TrueFlag,
           Target, MemAck,
    input  PC, MemReq, Commit, Busy, Done, Fault, CycleCnt
  );
endinterface

// File: rtl/prog_sequencer_cycle_counter.sv
// 16-bit saturating cycle counter with synchronous clear and enable; only
// instantiated when PROG_SEQ_CYCLE_COUNTER_EN is defined.
module cycle_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: owns the PC, runs fetch/execute/retire, stalls on memory.
// Optional executed-cycle counter enabled by PROG_SEQ_CYCLE_COUNTER_EN.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic Clk,
  input  logic Reset_n,
  prog_sequencer_if.master bus
);

  localparam logic [PC_W-1:0] PC_MAX   = '1;
  localparam logic [3:0]      TMO_LAST = 4'(MEM_TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic            done, done_nxt;
  logic            fault, fault_nxt;
  logic [3:0]      tcnt, tcnt_nxt;
  logic            memop, haltop, taken, step;
  logic            memreq, commit, busy;
  logic            unused_lsb;

  assign memop      = is_memop(bus.Instruction[CREATE_BIT], bus.Instruction[7:4]);
  assign haltop     = is_haltop(bus.Instruction[CREATE_BIT], bus.Instruction[7:4]);
  assign taken      = (bus.BeqEn & bus.ZeroFlag) | (bus.BtrEn & bus.TrueFlag);
  // Low nibble only feeds the external branch-target LUT.
  assign unused_lsb = ^bus.Instruction[3:0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
      pc    <= '0;
      done  <= 1'b0;
      fault <= 1'b0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      done  <= done_nxt;
      fault <= fault_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    done_nxt  = done;
    fault_nxt = fault;
    tcnt_nxt  = tcnt;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Start) begin
          pc_nxt    = bus.StartAddr;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (haltop) begin
          done_nxt  = 1'b1;
          state_nxt = ST_HALT;
        end else if (memop) begin
          if (bus.MemAck) begin
            step = 1'b1;
          end else begin
            tcnt_nxt  = '0;
            state_nxt = ST_MEMWAIT;
          end
        end else if (taken) begin
          pc_nxt = bus.Target;
        end else begin
          step = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        if (bus.MemAck) begin
          step      = 1'b1;
          state_nxt = ST_RUN;
        end else if (tcnt == TMO_LAST) begin
          fault_nxt = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = ST_HALT;
        end else begin
          tcnt_nxt = tcnt + 4'd1;
        end
      end
      ST_HALT: begin
        if (bus.Start) begin
          pc_nxt    = bus.StartAddr;
          done_nxt  = 1'b0;
          fault_nxt = 1'b0;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Sequential fall-through never wraps: running off the top of ROM faults.
    if (step) begin
      if (pc == PC_MAX) begin
        fault_nxt = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = ST_HALT;
      end else begin
        pc_nxt = pc + PC_W'(1);
      end
    end
  end

  always_comb begin
    memreq = 1'b0;
    commit = 1'b0;
    busy   = 1'b0;
    case (state)
      ST_RUN: begin
        busy   = 1'b1;
        memreq = memop;
        commit = !haltop && (!memop || bus.MemAck);
      end
      ST_MEMWAIT: begin
        busy   = 1'b1;
        memreq = 1'b1;
        commit = bus.MemAck;
      end
      default: ;
    endcase
  end

  assign bus.PC     = pc;
  assign bus.MemReq = memreq;
  assign bus.Commit = commit;
  assign bus.Busy   = busy;
  assign bus.Done   = done;
  assign bus.Fault  = fault;

`ifdef PROG_SEQ_CYCLE_COUNTER_EN
  logic start_ok;
  assign start_ok = bus.Start && (state == ST_IDLE || state == ST_HALT);

  cycle_counter u_cycle_counter (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (start_ok),
    .en    (busy),
    .cnt   (bus.CycleCnt)
  );
`else
  assign bus.CycleCnt = '0;
`endif

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Multi-cycle program sequencer for the 9-bit core. It owns the program counter, sequences fetch, execute and retire around the combinational decoder, and stalls load/store on a memory req/ack handshake. It resolves branch-equal and branch-true from ALU flags and stops on the halt opcode. It sits between instruction ROM, decoder, branch-target LUT, data memory and the top-level Start/Done handshake.

Parameters:
PC_W, 10, program counter width; ROM depth is 2^PC_W
MEM_TIMEOUT, 15, maximum MEMWAIT cycles before fault; 4-bit counter

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
Start  input  1  one-cycle pulse; launches a program at StartAddr
StartAddr  input  PC_W  first instruction address
Instruction  input  9  current ROM word at PC
BeqEn  input  1  decoder branch-equal flag
BtrEn  input  1  decoder branch-true flag
ZeroFlag  input  1  ALU equal/zero result
TrueFlag  input  1  ALU compare-true result
Target  input  PC_W  branch-target LUT output for Instruction[3:0]
MemAck  input  1  data memory access complete
PC  output  PC_W  program counter to ROM
MemReq  output  1  data memory access request
Commit  output  1  instruction retires this cycle; gates RegWrEn/MemWrite
Busy  output  1  RUN or MEMWAIT
Done  output  1  program halted
Fault  output  1  sticky; PC overrun or memory timeout
CycleCnt  output  16  executed-cycle count (optional feature)

Behaviour:
- Decoded classes: MEMOP = Instruction[8]==0 and Instruction[7:4] is 0000 (load) or 0011 (store). HALTOP = Instruction[8]==0 and Instruction[7:4]==1111.
- States: IDLE, RUN, MEMWAIT, HALT. Reset (async, Reset_n=0) forces IDLE, PC=0, Done=0, Fault=0, timeout counter=0, CycleCnt=0.
- MemReq and Commit are combinational from state, Instruction and MemAck. Both are 0 in IDLE and HALT.
- IDLE: on Start, PC<=StartAddr and go to RUN next cycle. Otherwise hold.
- RUN, non-mem, non-halt: Commit=1. Next PC = Target if (BeqEn&ZeroFlag)|(BtrEn&TrueFlag), else PC+1.
- RUN, MEMOP: MemReq=1.
  - MemAck in the same cycle: Commit=1, PC+1, stay in RUN.
  - No MemAck: go to MEMWAIT; PC holds; timeout counter cleared.
- MEMWAIT: MemReq=1, PC holds.
  - On MemAck: Commit=1, PC+1, go to RUN.
  - Otherwise the counter increments. On the cycle it reaches MEM_TIMEOUT without ack: set Fault, go to HALT, Commit=0.
- RUN, HALTOP: Commit=0, PC holds at the halt address, go to HALT.
- HALT: Done=1 (registered, asserted the cycle after the halt is seen). Start returns to RUN with PC<=StartAddr and clears Done and Fault.
- PC overrun: a sequential increment from PC = 2^PC_W-1 does not wrap. It sets Fault and goes to HALT with PC held. A branch to any Target is always legal.
- Start in RUN or MEMWAIT is ignored.
- Reset mid-operation: immediate return to IDLE. An outstanding MemReq drops asynchronously, and memory must tolerate the abandoned request.
- Busy=1 exactly in RUN and MEMWAIT.

Optional Feature:
- Macro: PROG_SEQ_CYCLE_COUNTER_EN.
- Defined: CycleCnt increments every cycle in RUN or MEMWAIT, saturating at 16'hFFFF. It clears on Start and holds in HALT, so it is readable after Done.
- Undefined: CycleCnt is tied to 0 and no counter flops are built.

Decomposition:
- Shared package: state encoding (IDLE=0, RUN=1, MEMWAIT=2, HALT=3) and opcode constants OP_LOAD=4'b0000, OP_STORE=4'b0011, OP_BEQ=4'b1010, OP_BTR=4'b1011, OP_HALT=4'b1111, CREATE_BIT=8. The decoder should adopt these too.
- One natural sub-module: cycle_counter (16-bit saturating, clear/enable), instantiated only under the macro.

Test Plan:
- Reset_n low mid-RUN, then release -> IDLE, PC=0, Busy=0, Done=0, Fault=0 immediately on assertion.
- Start with StartAddr=5; ROM holds add, add, halt at 5..7 -> PC 5,6,7; Commit high 2 cycles; Done=1 the cycle after PC=7; PC stays 7.
- Load at PC=3, MemAck delayed 3 cycles -> MemReq high 4 cycles; PC holds 3; single Commit on the ack cycle; PC=4 next.
- Beq with ZeroFlag=1, Target=20 -> PC=20. Same with ZeroFlag=0 -> PC+1. Btr with TrueFlag=1, Target=0 -> PC=0.
- Store with MemAck never asserted -> after MEM_TIMEOUT cycles Fault=1, Done=1, no Commit. A new Start clears both.
- PC_W=4, straight-line code to PC=15 with no halt -> Fault=1, HALT, PC=15. With the macro defined, CycleCnt=16 from StartAddr=0.
